// File: rtl/ysyx_25030081_ifu.sv
// Instruction fetch unit: holds the PC, fetches one 32-bit word per instruction over an
// AR/R read channel and presents it to the decoder with a valid/ready handshake.
// Only one fetch is ever in flight; the next one starts when the downstream stage returns
// the next PC.
module ysyx_25030081_ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset_n,
    // read address channel
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    // read data channel
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    // decoder handshake
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    // next PC from writeback / branch resolution
    input  logic        npc_valid,
    input  logic [31:0] npc,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [1:0] {
        ST_REQ,
        ST_WAIT_R,
        ST_HOLD,
        ST_WAIT_PC
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_pc, w_pc_next;
    logic        r_rready, w_rready_next;
    logic        r_inst_valid, w_inst_valid_next;
    logic [31:0] r_inst, w_inst_next;
    logic [31:0] r_inst_pc, w_inst_pc_next;
    logic        r_inst_fault, w_inst_fault_next;
    logic [31:0] r_fetch_cnt, w_fetch_cnt_next;

    logic        w_misaligned;

    assign w_misaligned = (r_pc[1:0] != 2'b00);

    // arvalid is a pure decode of the state/PC registers; the reset_n term keeps it low
    // while reset is held (the state register already sits in ST_REQ then).
    assign arvalid    = reset_n && (r_state == ST_REQ) && !w_misaligned;
    assign araddr     = r_pc;
    assign rready     = r_rready;
    assign inst_valid = r_inst_valid;
    assign inst       = r_inst;
    assign inst_pc    = r_inst_pc;
    assign inst_fault = r_inst_fault;
    assign fetch_cnt  = r_fetch_cnt;

    // Next-state and registered-output logic for the fetch sequence.
    always_comb begin
        w_state_next      = r_state;
        w_pc_next         = r_pc;
        w_rready_next     = r_rready;
        w_inst_valid_next = r_inst_valid;
        w_inst_next       = r_inst;
        w_inst_pc_next    = r_inst_pc;
        w_inst_fault_next = r_inst_fault;
        w_fetch_cnt_next  = r_fetch_cnt;

        case (r_state)
            ST_REQ: begin
                if (w_misaligned) begin
                    // Misaligned PC never reaches the bus; hand a faulting NOP downstream.
                    w_inst_next       = NOP_INST;
                    w_inst_pc_next    = r_pc;
                    w_inst_fault_next = 1'b1;
                    w_inst_valid_next = 1'b1;
                    w_state_next      = ST_HOLD;
                end else if (arvalid && arready) begin
                    w_rready_next = 1'b1;
                    w_state_next  = ST_WAIT_R;
                end
            end
            ST_WAIT_R: begin
                if (rvalid && r_rready) begin
                    if (rresp == 2'b00) begin
                        w_inst_next       = rdata;
                        w_inst_fault_next = 1'b0;
                    end else begin
                        w_inst_next       = NOP_INST;
                        w_inst_fault_next = 1'b1;
                    end
                    w_inst_pc_next    = r_pc;
                    w_rready_next     = 1'b0;
                    w_inst_valid_next = 1'b1;
                    w_state_next      = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (inst_ready) begin
                    w_inst_valid_next = 1'b0;
                    w_fetch_cnt_next  = r_fetch_cnt + 32'd1;
                    w_state_next      = ST_WAIT_PC;
                end
            end
            ST_WAIT_PC: begin
                if (npc_valid) begin
                    w_pc_next    = npc;
                    w_state_next = ST_REQ;
                end
            end
            default: begin
                w_state_next = ST_REQ;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight bus transaction.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_REQ;
            r_pc         <= RESET_PC;
            r_rready     <= 1'b0;
            r_inst_valid <= 1'b0;
            r_inst       <= NOP_INST;
            r_inst_pc    <= RESET_PC;
            r_inst_fault <= 1'b0;
            r_fetch_cnt  <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_rready     <= w_rready_next;
            r_inst_valid <= w_inst_valid_next;
            r_inst       <= w_inst_next;
            r_inst_pc    <= w_inst_pc_next;
            r_inst_fault <= w_inst_fault_next;
            r_fetch_cnt  <= w_fetch_cnt_next;
        end
    end

`ifndef SYNTHESIS
    // Flag a next-PC pulse that arrives while no fetch is waiting for it (it is dropped).
    always @(posedge clock) begin
        if (reset_n && npc_valid && (r_state != ST_WAIT_PC)) begin
            $warning("ifu: npc_valid outside WAIT_PC ignored, npc=%08h", npc);
        end
    end
`endif

endmodule
